// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one external combinational 32-bit barrel shifter
// between two requesters (port 0 = CPU execute, port 1 = peripheral/debug).
// One transaction at a time: IDLE (grant + latch operands), SHIFT (capture
// shifter output), RESP (hold result for the owner until it is consumed).
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration on
// contention; otherwise port 0 has fixed priority.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic [4:0]  req0_shamt,
    input  logic        req0_lr,
    input  logic        req0_al,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    input  logic [4:0]  req1_shamt,
    input  logic        req1_lr,
    input  logic        req1_al,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,

    output logic [31:0] sh_indata,
    output logic [4:0]  sh_shamt,
    output logic        sh_lr,
    output logic        sh_al,
    input  logic [31:0] sh_outdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Operand register feeding the shifter directly
    logic [31:0] op_data;
    logic [4:0]  op_shamt;
    logic        op_lr;
    logic        op_al;

    logic        owner;       // port that owns the in-flight transaction
    logic        last_grant;  // port granted most recently
    logic [31:0] result;

    logic        grant_any;
    logic        grant_id;
    logic        owner_ready;
    logic        accept;

    // Arbitration: pick the winning port among valid requesters
    always_comb begin
        grant_any = req0_valid | req1_valid;
`ifdef SHIFT_ARB_RR_EN
        // On contention, grant the port that did not win last time
        grant_id  = req1_valid & (~req0_valid | ~last_grant);
`else
        // Port 0 always wins contention
        grant_id  = req1_valid & ~req0_valid;
`endif
    end

    assign owner_ready = owner ? resp1_ready : resp0_ready;
    assign accept      = (state == IDLE) && grant_any;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and combinational request-ready outputs
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                state_next = RESP;
            end
            RESP: begin
                if (owner_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand, owner and grant-history capture on an accepted request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_data    <= '0;
            op_shamt   <= '0;
            op_lr      <= 1'b0;
            op_al      <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_data    <= grant_id ? req1_data  : req0_data;
            op_shamt   <= grant_id ? req1_shamt : req0_shamt;
            op_lr      <= grant_id ? req1_lr    : req0_lr;
            op_al      <= grant_id ? req1_al    : req0_al;
            owner      <= grant_id;
            last_grant <= grant_id;
        end
    end

    // Result capture and registered response-valid flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result      <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            if (state == SHIFT) begin
                result      <= sh_outdata;
                resp0_valid <= ~owner;
                resp1_valid <= owner;
            end else if ((state == RESP) && owner_ready) begin
                resp0_valid <= 1'b0;
                resp1_valid <= 1'b0;
            end
        end
    end

    assign sh_indata = op_data;
    assign sh_shamt  = op_shamt;
    assign sh_lr     = op_lr;
    assign sh_al     = op_al;
    assign resp_data = result;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter. Provides a behavioural
// barrel shifter on the sh_* interface. Expected grant order on contention
// follows SHIFT_ARB_RR_EN when it is defined.
module tb_shift_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_lr, req0_al;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic        req1_valid, req1_ready, req1_lr, req1_al;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_data;
    logic [31:0] sh_indata, sh_outdata;
    logic [4:0]  sh_shamt;
    logic        sh_lr, sh_al;
    logic        busy;

    int errors;
    int checks;

    shift_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_data   (req0_data),
        .req0_shamt  (req0_shamt),
        .req0_lr     (req0_lr),
        .req0_al     (req0_al),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_data   (req1_data),
        .req1_shamt  (req1_shamt),
        .req1_lr     (req1_lr),
        .req1_al     (req1_al),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_data   (resp_data),
        .sh_indata   (sh_indata),
        .sh_shamt    (sh_shamt),
        .sh_lr       (sh_lr),
        .sh_al       (sh_al),
        .sh_outdata  (sh_outdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural barrel shifter
    always_comb begin
        if (sh_lr)
            sh_outdata = sh_indata << sh_shamt;
        else if (sh_al)
            sh_outdata = $unsigned($signed(sh_indata) >>> sh_shamt);
        else
            sh_outdata = sh_indata >> sh_shamt;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req0_ready"},  {31'd0, req0_ready},  32'd0);
        check({tag, ".req1_ready"},  {31'd0, req1_ready},  32'd0);
        check({tag, ".resp0_valid"}, {31'd0, resp0_valid}, 32'd0);
        check({tag, ".resp1_valid"}, {31'd0, resp1_valid}, 32'd0);
        check({tag, ".resp_data"},   resp_data,            32'd0);
        check({tag, ".sh_indata"},   sh_indata,            32'd0);
        check({tag, ".sh_shamt"},    {27'd0, sh_shamt},    32'd0);
        check({tag, ".sh_lr"},       {31'd0, sh_lr},       32'd0);
        check({tag, ".sh_al"},       {31'd0, sh_al},       32'd0);
        check({tag, ".busy"},        {31'd0, busy},        32'd0);
    endtask

    // Single-port transaction with immediate response ready; starts and ends in IDLE
    task automatic single_txn(input string tag, input logic port, input logic [31:0] data,
                              input logic [4:0] shamt, input logic lr, input logic al,
                              input logic [31:0] exp);
        if (port == 1'b0) begin
            req0_valid = 1'b1; req0_data = data; req0_shamt = shamt; req0_lr = lr; req0_al = al;
            resp0_ready = 1'b1;
        end else begin
            req1_valid = 1'b1; req1_data = data; req1_shamt = shamt; req1_lr = lr; req1_al = al;
            resp1_ready = 1'b1;
        end
        #1;
        check({tag, ".T.ready0"}, {31'd0, req0_ready}, {31'd0, ~port});
        check({tag, ".T.ready1"}, {31'd0, req1_ready}, {31'd0, port});
        check({tag, ".T.busy"},   {31'd0, busy},       32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, ".T1.busy"},   {31'd0, busy},        32'd1);
        check({tag, ".T1.indata"}, sh_indata,            data);
        check({tag, ".T1.valid0"}, {31'd0, resp0_valid}, 32'd0);
        check({tag, ".T1.valid1"}, {31'd0, resp1_valid}, 32'd0);
        tick();
        check({tag, ".T2.valid0"}, {31'd0, resp0_valid}, {31'd0, ~port});
        check({tag, ".T2.valid1"}, {31'd0, resp1_valid}, {31'd0, port});
        check({tag, ".T2.data"},   resp_data,            exp);
        tick();
        check({tag, ".T3.valid0"}, {31'd0, resp0_valid}, 32'd0);
        check({tag, ".T3.valid1"}, {31'd0, resp1_valid}, 32'd0);
        check({tag, ".T3.busy"},   {31'd0, busy},        32'd0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    logic exp_port;

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_lr = 1'b0; req0_al = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_lr = 1'b0; req1_al = 1'b0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Port 0 only: 1 << 31
        single_txn("p0_shl31", 1'b0, 32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000);

        // Port 1 only: arithmetic then logical right shift by 4
        single_txn("p1_sra4", 1'b1, 32'h8000_0000, 5'd4, 1'b0, 1'b1, 32'hF800_0000);
        single_txn("p1_srl4", 1'b1, 32'h8000_0000, 5'd4, 1'b0, 1'b0, 32'h0800_0000);

        // Contention: both valid continuously; last grant was port 1
        req0_valid = 1'b1; req0_data = 32'h1; req0_shamt = 5'd1; req0_lr = 1'b1; req0_al = 1'b0;
        req1_valid = 1'b1; req1_data = 32'h2; req1_shamt = 5'd1; req1_lr = 1'b1; req1_al = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
            exp_port = (i % 2 == 1);
`else
            exp_port = 1'b0;
`endif
            #1;
            check("contend.ready0", {31'd0, req0_ready}, {31'd0, ~exp_port});
            check("contend.ready1", {31'd0, req1_ready}, {31'd0, exp_port});
            tick();
            tick();
            check("contend.valid0", {31'd0, resp0_valid}, {31'd0, ~exp_port});
            check("contend.valid1", {31'd0, resp1_valid}, {31'd0, exp_port});
            check("contend.data",   resp_data, exp_port ? 32'h4 : 32'h2);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
        tick();

        // Backpressure on port 0 while port 1 waits
        req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_shamt = 5'd8; req0_lr = 1'b0; req0_al = 1'b0;
        #1;
        check("bp.grant0", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 32'h3; req1_shamt = 5'd2; req1_lr = 1'b1; req1_al = 1'b0;
        resp1_ready = 1'b1;
        #1;
        check("bp.shift.ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp.hold.valid0", {31'd0, resp0_valid}, 32'd1);
            check("bp.hold.valid1", {31'd0, resp1_valid}, 32'd0);
            check("bp.hold.data",   resp_data, 32'h0012_3456);
            check("bp.hold.ready1", {31'd0, req1_ready}, 32'd0);
            tick();
        end
        resp0_ready = 1'b1;
        #1;
        check("bp.release.valid0", {31'd0, resp0_valid}, 32'd1);
        check("bp.release.ready1", {31'd0, req1_ready}, 32'd0);
        tick();
        resp0_ready = 1'b0;
        #1;
        check("bp.after.valid0", {31'd0, resp0_valid}, 32'd0);
        check("bp.after.ready1", {31'd0, req1_ready},  32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("bp.p1.valid1", {31'd0, resp1_valid}, 32'd1);
        check("bp.p1.data",   resp_data, 32'hC);
        tick();
        resp1_ready = 1'b0;
        check("bp.p1.done", {31'd0, resp1_valid}, 32'd0);

        // Reset asserted during SHIFT discards the transaction
        req0_valid = 1'b1; req0_data = 32'hF0F0_F0F0; req0_shamt = 5'd4; req0_lr = 1'b0; req0_al = 1'b1;
        resp0_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        check("rst_mid.busy_shift", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        tick();
        check("rst_mid.post.valid0", {31'd0, resp0_valid}, 32'd0);
        check("rst_mid.post.busy",   {31'd0, busy},        32'd0);
        tick();
        check("rst_mid.post2.valid0", {31'd0, resp0_valid}, 32'd0);
        resp0_ready = 1'b0;

        // After reset last_grant is port 1, so port 0 wins contention in both modes
        req0_valid = 1'b1; req0_data = 32'h1; req0_shamt = 5'd1; req0_lr = 1'b1; req0_al = 1'b0;
        req1_valid = 1'b1; req1_data = 32'h2; req1_shamt = 5'd1; req1_lr = 1'b1; req1_al = 1'b0;
        resp0_ready = 1'b1;
        #1;
        check("rst_mid.grant0", {31'd0, req0_ready}, 32'd1);
        check("rst_mid.grant1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("rst_mid.new.valid0", {31'd0, resp0_valid}, 32'd1);
        check("rst_mid.new.data",   resp_data, 32'h2);
        tick();
        resp0_ready = 1'b0;

        // shamt = 0 passes data through with the full sequence
        single_txn("p0_shamt0", 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

- Shares one combinational 32-bit barrel shifter between two requesters: port 0 is the CPU execute stage, port 1 is the peripheral/debug side.
- Arbitrates between the two ports and registers the winner's operands.
- Drives the shifter from those registers, captures the result, and returns it to the winning port over a valid/ready handshake.
- Handles one transaction at a time.

## Interface

Parameters:
- none

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low (single clock; polarity and synchronicity fixed)
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_data / req1_data  in  32  operand to shift
- req0_shamt / req1_shamt  in  5  shift amount, 0..31
- req0_lr / req1_lr  in  1  direction: 1 = left, 0 = right
- req0_al / req1_al  in  1  right-shift type: 1 = arithmetic, 0 = logical; ignored when lr = 1
- resp0_valid / resp1_valid  out  1  result available for port 0 / 1
- resp0_ready / resp1_ready  in  1  port consumes result
- resp_data  out  32  shift result, shared by both ports; qualified by respN_valid
- sh_indata  out  32  to shifter: operand
- sh_shamt  out  5  to shifter: shift amount
- sh_lr  out  1  to shifter: direction
- sh_al  out  1  to shifter: arithmetic select
- sh_outdata  in  32  from shifter, combinational, same cycle
- busy  out  1  high in any state other than IDLE

## Operation

- FSM states: IDLE, SHIFT, RESP. Reset state: IDLE.
- IDLE:
  - If any reqN_valid is high, choose a winner by the arbitration rule.
  - Assert reqN_ready for the winner only, combinationally, that cycle.
  - On the clock edge, latch data/shamt/lr/al into the operand register, latch the owner ID, update last_grant, go to SHIFT.
  - With no request: stay in IDLE; both ready outputs low.
- SHIFT:
  - sh_* outputs come straight from the operand register.
  - Capture sh_outdata into the result register; go to RESP.
  - No ready outputs asserted.
- RESP:
  - Hold respN_valid high for the owner only; resp_data = result register.
  - Stay in RESP while respN_ready for the owner is low. Result and owner stay stable.
  - respN_ready on the non-owner port is ignored.
  - Owner's respN_ready high → go to IDLE.
  - A new request cannot be accepted in the same cycle as the response; it is accepted in the next IDLE cycle.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the rule is set under Configuration.
- Operand semantics, implemented by the shifter and not altered here:
  - lr = 1: logical left shift.
  - lr = 0, al = 0: logical right shift.
  - lr = 0, al = 1: right shift filling with data[31].
  - shamt = 0 passes data through unchanged but still completes a full transaction.
- Requests are never dropped or reordered. A requester holding valid low after grant has no effect, because the operands are already latched.

## Timing

- Request handshake in cycle T (reqN_valid and reqN_ready both high).
- SHIFT in T+1; respN_valid first high in T+2.
- Minimum turnaround is 3 cycles per transaction: IDLE, SHIFT, RESP with immediate ready.
- Each cycle of response backpressure adds one cycle.
- Reset values:
  - state = IDLE
  - req0_ready = req1_ready = 0
  - resp0_valid = resp1_valid = 0
  - resp_data = 0
  - sh_indata = 0, sh_shamt = 0, sh_lr = 0, sh_al = 0
  - busy = 0
  - last_grant = 1, so port 0 wins the first contention
- Reset asserted mid-transaction, in SHIFT or RESP: the transaction is discarded and no response is issued. The first cycle after rst_n rises is IDLE.
- reqN_ready depends combinationally on reqN_valid and state. resp_data and respN_valid come only from registers.

## Configuration

- SHIFT_ARB_RR_EN defined: round-robin.
  - When both ports are valid in IDLE, grant the port not equal to last_grant.
  - last_grant updates on every grant, including uncontended ones.
- SHIFT_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins contention; port 1 can starve.
  - last_grant is still maintained but does not affect arbitration.

## Test plan

- Port 0 only: data = 0x00000001, shamt = 31, lr = 1; resp0_ready held high → resp_data = 0x80000000, resp0_valid high exactly at T+2 for one cycle, resp1_valid never high.
- Port 1 only: data = 0x80000000, shamt = 4, lr = 0, al = 1 → resp_data = 0xF8000000; then al = 0 → 0x08000000.
- Both ports valid continuously, each with shamt = 1, lr = 1, port 0 data 0x1, port 1 data 0x2:
  - with SHIFT_ARB_RR_EN, grants alternate 0, 1, 0, 1 with results 0x2, 0x4, 0x2, 0x4;
  - without it, only port 0 is granted.
- Backpressure: resp0_ready low for 5 cycles → resp0_valid and resp_data stable the whole time; req1 held valid meanwhile is not granted until the cycle after resp0_ready rises.
- Reset mid-op: rst_n low during SHIFT for 1 cycle → no respN_valid afterwards, all outputs at reset values, next request completes normally.
- shamt = 0 with data 0xDEADBEEF on port 0 → resp_data = 0xDEADBEEF after the normal 3-cycle sequence.
